// File: rtl/radix8_booth_mul_seq.sv
// Sequential radix-8 Booth multiplier: one Booth digit per cycle, signed or unsigned.
// Operands are accepted with a valid/ready handshake. The product is presented with
// out_valid and held stable until the consumer takes it.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake (a, x, signed_mode)
//   a, x [K-1:0]                multiplicand, multiplier
//   signed_mode                 1: both operands two's complement, 0: both unsigned
//   out_valid/out_ready         product handshake
//   product [2K-1:0]            a*x, held until replaced by the next result
//   busy                        high whenever an operation is in flight or held
module radix8_booth_mul_seq #(
   parameter int unsigned K = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [K-1:0]   a,
   input  logic [K-1:0]   x,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*K-1:0] product,
   output logic           busy
);

   localparam int unsigned N  = (K + 3) / 3;   // Booth digits covering K+1 bits
   localparam int unsigned XW = 3 * N + 1;     // multiplier shift reg incl. x[-1]
   localparam int unsigned HW = K + 4;         // accumulator high part (|hi + 4a| < 2^(K+3))
   localparam int unsigned LW = 3 * N;         // low product bits shifted out
   localparam int unsigned CW = $clog2(N);
   localparam int unsigned PW = 2 * K;

   typedef enum logic [1:0] {IDLE, PRECOMP, ITER, HOLD} state_t;

   state_t               state_q, state_d;
   logic signed [K:0]    a_q;
   logic signed [K+2:0]  a3_q;
   logic signed [XW-1:0] xs_q;
   logic signed [HW-1:0] hi_q;
   logic [LW-1:0]        lo_q;
   logic [CW-1:0]        cnt_q;

   logic                 accept_c, last_c, neg_c;
   logic [2:0]           mag_c;
   logic signed [K:0]    x_ext_c;
   logic signed [HW-1:0] mabs_c, mult_c, sum_c, hi_nxt_c;
   logic [LW-1:0]        lo_nxt_c;

   // Next-state decode
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      last_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               state_d  = PRECOMP;
            end
         end
         PRECOMP: state_d = ITER;
         ITER: begin
            if (cnt_q == '0) begin
               last_c  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with handshake flags registered from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == HOLD);
         busy      <= (state_d != IDLE);
      end
   end

   // Digit recoding from x[i+2:i-1] and selection of the partial product
   always_comb begin
      x_ext_c = {signed_mode & x[K-1], x};
      neg_c   = xs_q[3];
      unique case (xs_q[3:0])
         4'b0001, 4'b0010, 4'b1101, 4'b1110: mag_c = 3'd1;
         4'b0011, 4'b0100, 4'b1011, 4'b1100: mag_c = 3'd2;
         4'b0101, 4'b0110, 4'b1001, 4'b1010: mag_c = 3'd3;
         4'b0111, 4'b1000:                   mag_c = 3'd4;
         default:                            mag_c = 3'd0;
      endcase
      unique case (mag_c)
         3'd1:    mabs_c = HW'(a_q);
         3'd2:    mabs_c = HW'(a_q) <<< 1;
         3'd3:    mabs_c = HW'(a3_q);
         3'd4:    mabs_c = HW'(a_q) <<< 2;
         default: mabs_c = '0;
      endcase
      mult_c   = neg_c ? -mabs_c : mabs_c;
      sum_c    = hi_q + mult_c;
      // Arithmetic shift of {hi,lo} by one digit; lo collects the finished low bits
      hi_nxt_c = sum_c >>> 3;
      lo_nxt_c = {sum_c[2:0], lo_q[LW-1:3]};
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q     <= '0;
         a3_q    <= '0;
         xs_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         product <= '0;
      end else begin
         if (accept_c) begin
            a_q  <= {signed_mode & a[K-1], a};
            xs_q <= {(XW-1)'(x_ext_c), 1'b0};
            hi_q <= '0;
            lo_q <= '0;
         end
         if (state_q == PRECOMP) begin
            a3_q  <= (K+3)'(a_q) + ((K+3)'(a_q) <<< 1);
            cnt_q <= CW'(N - 1);
         end
         if (state_q == ITER) begin
            hi_q  <= hi_nxt_c;
            lo_q  <= lo_nxt_c;
            xs_q  <= xs_q >>> 3;
            cnt_q <= cnt_q - CW'(1);
            if (last_c) product <= PW'({hi_nxt_c, lo_nxt_c});
         end
      end
   end

endmodule

// File: tb/tb_radix8_booth_mul_seq.sv
// Bench for radix8_booth_mul_seq: one K=32 and one K=8 instance, a transaction-level
// timing/arithmetic model, and an every-cycle compare of all outputs against it.
module tb_radix8_booth_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv[2], sm[2], ordy[2], ir[2], ov[2], bz[2];
   logic [31:0] a32, x32;
   logic [7:0]  a8, x8;
   logic [63:0] p32;
   logic [15:0] p8;

   int n_chk = 0;
   int n_fail = 0;

   // Model state per instance
   bit        mb[2], mv[2];
   int        mc[2];
   bit [63:0] mp[2], mpend[2];
   int        nacc[2], ncons[2], dacc[2], dcons[2], n_ops[2];

   typedef struct {
      logic [31:0] a;
      logic [31:0] x;
      bit          s;
      logic [63:0] p;
   } vec_t;
   vec_t vt[8];

   radix8_booth_mul_seq #(.K(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a32), .x(x32),
      .signed_mode(sm[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .product(p32),
      .busy(bz[0])
   );

   radix8_booth_mul_seq #(.K(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a8), .x(x8),
      .signed_mode(sm[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .product(p8),
      .busy(bz[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Exact k-bit x k-bit product, computed modulo 2^64 then cut to 2k bits
   function automatic logic [63:0] exp_prod(input int k, input logic [31:0] av,
                                            input logic [31:0] xv, input bit s);
      logic [63:0] mk, ea, ex, m;
      mk = (64'd1 << k) - 64'd1;
      ea = {32'd0, av} & mk;
      ex = {32'd0, xv} & mk;
      if (s && ea[k-1]) ea = ea | ~mk;
      if (s && ex[k-1]) ex = ex | ~mk;
      m = ea * ex;
      if (k < 32) m = m & ((64'd1 << (2 * k)) - 64'd1);
      return m;
   endfunction

   function automatic logic [31:0] pick(input int k);
      logic [31:0] mk;
      mk = (k == 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
      case ($urandom_range(0, 7))
         0:       return mk;
         1:       return 32'd1 << (k - 1);
         2:       return mk >> 1;
         3:       return 32'd0;
         default: return $urandom & mk;
      endcase
   endfunction

   function automatic logic [63:0] get_p(input int id);
      return (id == 0) ? p32 : {48'd0, p8};
   endfunction

   // Model: acceptance in IDLE, result N+1 edges later, held until out_ready
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int id = 0; id < 2; id++) begin
            mb[id] = 1'b0; mv[id] = 1'b0; mc[id] = 0; mp[id] = '0;
         end
      end else begin
         for (int id = 0; id < 2; id++) begin
            int k;
            logic [31:0] av, xv;
            k  = (id == 0) ? 32 : 8;
            av = (id == 0) ? a32 : {24'd0, a8};
            xv = (id == 0) ? x32 : {24'd0, x8};
            if (iv[id] && ir[id]) dacc[id]++;
            if (ov[id] && ordy[id]) dcons[id]++;
            if (!mb[id]) begin
               if (iv[id]) begin
                  mb[id]    = 1'b1;
                  mc[id]    = (k + 3) / 3 + 1;
                  mpend[id] = exp_prod(k, av, xv, sm[id]);
                  nacc[id]++;
               end
            end else if (mc[id] > 0) begin
               mc[id]--;
               if (mc[id] == 0) begin
                  mv[id] = 1'b1;
                  mp[id] = mpend[id];
               end
            end else if (ordy[id]) begin
               mb[id] = 1'b0;
               mv[id] = 1'b0;
               ncons[id]++;
            end
         end
      end
   end

   // Every-cycle compare of all outputs
   always @(negedge clk) begin
      for (int id = 0; id < 2; id++) begin
         chk($sformatf("in_ready[%0d]", id), 64'(ir[id]), 64'(!mb[id]));
         chk($sformatf("busy[%0d]", id), 64'(bz[id]), 64'(mb[id]));
         chk($sformatf("out_valid[%0d]", id), 64'(ov[id]), 64'(mv[id]));
         chk($sformatf("product[%0d]", id), get_p(id), mp[id]);
      end
   end

   task automatic set_ops(input int id, input logic [31:0] av, input logic [31:0] xv,
                          input bit s);
      if (id == 0) begin
         a32 = av; x32 = xv;
      end else begin
         a8 = av[7:0]; x8 = xv[7:0];
      end
      sm[id] = s;
   endtask

   // Called at a negedge; returns at the negedge after the product is consumed
   task automatic do_op(input int id, input logic [31:0] av, input logic [31:0] xv,
                        input bit s, input int hold, output int lat,
                        output logic [63:0] prod);
      int g;
      set_ops(id, av, xv, s);
      iv[id]   = 1'b1;
      ordy[id] = 1'b0;
      g = 0;
      while (!ir[id] && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!ir[id]) chk("accept_timeout", 64'(ir[id]), 64'd1);
      @(negedge clk);
      lat = 1;
      while (!ov[id] && lat < 100) begin
         set_ops(id, $urandom, $urandom, 1'($urandom));
         iv[id]   = 1'($urandom);
         ordy[id] = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      if (!ov[id]) chk("result_timeout", 64'(ov[id]), 64'd1);
      ordy[id] = 1'b0;
      prod = get_p(id);
      repeat (hold) begin
         set_ops(id, $urandom, $urandom, 1'($urandom));
         iv[id] = 1'($urandom);
         @(negedge clk);
      end
      // Offer a junk operand on the consuming edge: it must not be taken
      set_ops(id, $urandom, $urandom, 1'($urandom));
      iv[id]   = 1'b1;
      ordy[id] = 1'b1;
      @(negedge clk);
      ordy[id] = 1'b0;
      iv[id]   = 1'b0;
      n_ops[id]++;
   endtask

   task automatic rand_run(input int id);
      int k, lat;
      logic [63:0] prod;
      logic [31:0] av, xv;
      k = (id == 0) ? 32 : 8;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1000; i++) begin
            av = pick(k);
            xv = pick(k);
            do_op(id, av, xv, bit'(m), $urandom_range(0, 3), lat, prod);
            chk($sformatf("rand_lat[%0d]", id), 64'(lat), 64'((k + 3) / 3 + 2));
            chk($sformatf("rand_prod[%0d]", id), prod, exp_prod(k, av, xv, bit'(m)));
         end
      end
   endtask

   initial begin
      int lat;
      logic [63:0] prod;
      rst = 1'b0;
      for (int id = 0; id < 2; id++) begin
         iv[id] = 1'b0; sm[id] = 1'b0; ordy[id] = 1'b0;
      end
      a32 = '0; x32 = '0; a8 = '0; x8 = '0;
      vt[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
      vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      vt[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
      vt[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
      vt[4] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
      vt[5] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 64'h0000_0006_FFFF_FFEB};
      vt[6] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F};
      vt[7] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_busy", 64'(bz[0]), 64'd0);
      chk("rst_product", p32, 64'd0);

      // First operand is offered on the same negedge reset releases
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("model_pin%0d", i), exp_prod(32, vt[i].a, vt[i].x, vt[i].s), vt[i].p);
         do_op(0, vt[i].a, vt[i].x, vt[i].s, (i == 2) ? 5 : 0, lat, prod);
         chk($sformatf("dir_lat%0d", i), 64'(lat), 64'd13);
         chk($sformatf("dir_prod%0d", i), prod, vt[i].p);
      end

      // Abort in the fourth ITER cycle with inputs churning
      set_ops(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      iv[0] = 1'b1;
      @(negedge clk);
      repeat (4) begin
         set_ops(0, $urandom, $urandom, 1'($urandom));
         iv[0] = ~iv[0];
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      chk("abort_in_ready", 64'(ir[0]), 64'd1);
      chk("abort_out_valid", 64'(ov[0]), 64'd0);
      chk("abort_busy", 64'(bz[0]), 64'd0);
      chk("abort_product", p32, 64'd0);
      @(negedge clk);
      rst   = 1'b1;
      iv[0] = 1'b0;
      repeat (3) @(negedge clk);
      do_op(0, 32'd3, 32'd5, 1'b0, 1, lat, prod);
      chk("abort_next_lat", 64'(lat), 64'd13);
      chk("abort_next_prod", prod, 64'd15);

      fork
         rand_run(0);
         rand_run(1);
      join

      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
         chk($sformatf("acc_count[%0d]", id), 64'(dacc[id]), 64'(nacc[id]));
         chk($sformatf("cons_count[%0d]", id), 64'(dcons[id]), 64'(ncons[id]));
         chk($sformatf("ops_count[%0d]", id), 64'(dcons[id]), 64'(n_ops[id]));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
